// File: rtl/loader_pkg.sv
// Shared definitions for the instruction loader: FSM states, error codes and
// the byte-to-word packing width.
package loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_CSUM = 2'd2;
  localparam logic [1:0] ERR_TMO  = 2'd3;

  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/word_packer.sv
// Packs a little-endian byte stream into 32-bit words; word_valid_o fires
// combinationally with the byte that completes a word.
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        word_valid_o,
  output logic [31:0] word_o
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] shreg_q, shreg_d;

  always_comb begin
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    if (clear_i) begin
      cnt_d   = '0;
      shreg_d = '0;
    end else if (byte_valid_i) begin
      cnt_d   = cnt_q + 2'd1;
      shreg_d = {byte_i, shreg_q[31:8]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      shreg_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
    end
  end

  // Earlier bytes sit in the top three lanes, so the completing byte tops them off.
  assign word_valid_o = byte_valid_i && !clear_i && (cnt_q == 2'(WORD_BYTES - 1));
  assign word_o       = {byte_i, shreg_q[31:8]};

endmodule

// File: rtl/instr_loader.sv
// Framed byte-stream program loader: writes words into instruction memory and
// holds the CPU in reset until a frame with a valid checksum has landed.
module instr_loader
  import loader_pkg::*;
#(
  parameter int unsigned          ADDR_W    = 32,
  parameter logic [ADDR_W-1:0]    BASE_ADDR = '0,
  parameter int unsigned          MAX_WORDS = 64,
  parameter int unsigned          TIMEOUT   = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [15:0]       words_loaded
);

  localparam int unsigned IDLE_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [7:0]          len_lo_q, len_lo_d;
  logic [15:0]         n_q, n_d;
  logic [15:0]         k_q, k_d;
  logic [7:0]          xor_q, xor_d;
  logic [IDLE_W-1:0]   idle_q, idle_d;
  logic [1:0]          err_code_q, err_code_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;

  logic        accept;
  logic        timed_out;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] len_full;

  assign in_ready  = rst && (state_q inside {LEN0, LEN1, DATA, CSUM});
  assign accept    = in_valid && in_ready;
  assign timed_out = (idle_q == IDLE_W'(TIMEOUT));
  assign len_full  = {in_data, len_lo_q};

  word_packer u_packer (
    .clk         (clk),
    .rst         (rst),
    .clear_i     (state_q != DATA),
    .byte_valid_i(accept),
    .byte_i      (in_data),
    .word_valid_o(word_valid),
    .word_o      (word)
  );

  always_comb begin
    state_d     = state_q;
    len_lo_d    = len_lo_q;
    n_d         = n_q;
    k_d         = k_q;
    xor_d       = xor_q;
    err_code_d  = err_code_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      LEN0: begin
        if (accept) begin
          len_lo_d = in_data;
          xor_d    = xor_q ^ in_data;
          state_d  = LEN1;
        end
      end
      LEN1: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          n_d   = len_full;
          if (len_full > 16'(MAX_WORDS)) begin
            state_d    = ERR;
            err_code_d = ERR_LEN;
          end else if (len_full == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end else if (timed_out) begin
          state_d    = ERR;
          err_code_d = ERR_TMO;
        end
      end
      DATA: begin
        if (accept) begin
          xor_d = xor_q ^ in_data;
          if (word_valid) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = BASE_ADDR + (ADDR_W'(k_q) << 2);
            mem_wdata_d = word;
            k_d         = k_q + 16'd1;
            if (k_q + 16'd1 == n_q) state_d = CSUM;
          end
        end else if (timed_out) begin
          state_d    = ERR;
          err_code_d = ERR_TMO;
        end
      end
      CSUM: begin
        if (accept) begin
          if (in_data == xor_q) begin
            state_d = DONE;
          end else begin
            state_d    = ERR;
            err_code_d = ERR_CSUM;
          end
        end else if (timed_out) begin
          state_d    = ERR;
          err_code_d = ERR_TMO;
        end
      end
      DONE, ERR: begin
        if (start) begin
          state_d    = LEN0;
          err_code_d = ERR_NONE;
          k_d        = '0;
          xor_d      = '0;
        end
      end
      default: state_d = LEN0;
    endcase

    // Idle time only counts while a frame is open and the state is stable.
    if (accept || (state_d != state_q) || !(state_q inside {LEN1, DATA, CSUM}))
      idle_d = '0;
    else
      idle_d = idle_q + IDLE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= LEN0;
      len_lo_q    <= '0;
      n_q         <= '0;
      k_q         <= '0;
      xor_q       <= '0;
      idle_q      <= '0;
      err_code_q  <= ERR_NONE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= BASE_ADDR;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      len_lo_q    <= len_lo_d;
      n_q         <= n_d;
      k_q         <= k_d;
      xor_q       <= xor_d;
      idle_q      <= idle_d;
      err_code_q  <= err_code_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign done         = (state_q == DONE);
  assign err          = (state_q == ERR);
  assign cpu_rst      = (state_q != DONE);
  assign err_code     = err_code_q;
  assign words_loaded = k_q;

endmodule

// File: doc/instr_loader.md
Name: instr_loader

Overview:
Hardware program loader. It receives a framed little-endian byte stream from a host over a valid/ready handshake and writes 32-bit words into the pipelined CPU's instruction memory. It holds the CPU in reset until a complete frame with a matching checksum has been written. It sits between the host/debug link and the instr-memory write port, and drives the CPU's active-high reset.

Parameters:
ADDR_W, 32, width of mem_addr
BASE_ADDR, 0, byte address of word 0
MAX_WORDS, 64, largest legal word count (256-byte instruction memory)
TIMEOUT, 1000, maximum idle cycles between bytes once a frame has started

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset
start  in  1  one-cycle pulse; rearms the loader from DONE or ERR
in_valid  in  1  host byte valid
in_data  in  8  host byte
in_ready  out  1  loader can accept a byte
mem_we  out  1  instr-memory word write strobe
mem_addr  out  ADDR_W  byte address, word aligned
mem_wdata  out  32  word to write
cpu_rst  out  1  active-high reset to mips_pipelined
done  out  1  load completed, checksum OK
err  out  1  load failed
err_code  out  2  0 none, 1 length overflow, 2 checksum mismatch, 3 timeout
words_loaded  out  16  words written in the current or last frame

Behaviour:
- Reset (rst==0 at a rising edge): state=LEN0. Outputs: mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_rst=1, done=0, err=0, err_code=0, words_loaded=0. in_ready is forced 0 while rst==0.
- A byte is accepted when in_valid && in_ready at a rising edge. in_ready=1 exactly in LEN0, LEN1, DATA and CSUM.
- Frame format, in order:
  - length low byte, then length high byte: N = word count, 16 bits.
  - 4*N data bytes, little-endian: the first byte of each word is bits [7:0].
  - one checksum byte = XOR of both length bytes and all data bytes.
- LEN0: accept low length byte, go to LEN1. No timeout applies in this state.
- LEN1: accept high length byte.
  - N > MAX_WORDS: go to ERR, err_code=1.
  - N == 0: go to CSUM.
  - Otherwise: go to DATA.
- DATA: a 2-bit byte counter packs bytes into a word.
  - On acceptance of the 4th byte: mem_we=1 for exactly one cycle on the next cycle, with mem_addr=BASE_ADDR+4*k and mem_wdata=the assembled word. k increments and words_loaded=k+1.
  - Back-to-back bytes have no stall; in_ready stays 1 during the write cycle.
  - After the 4th byte of word N-1, go to CSUM.
- CSUM: accept one byte.
  - Equal to the running XOR: go to DONE.
  - Otherwise: go to ERR, err_code=2.
  - The final mem_we always occurs no later than the cycle done rises.
- DONE: done=1, cpu_rst=0, in_ready=0. Stay here until start or reset.
- ERR: err=1, cpu_rst=1, in_ready=0. err_code holds its value. Memory already written is left as is.
- Timeout (LEN1, DATA and CSUM only):
  - An idle counter clears on every accepted byte and on every state entry.
  - It increments on each cycle with no acceptance.
  - When it reaches TIMEOUT, go to ERR with err_code=3 on the next edge.
- start in DONE or ERR: next cycle cpu_rst=1, done=0, err=0, err_code=0, words_loaded=0, XOR=0, k=0, state=LEN0.
- start in any other state is ignored.
- If start and rst==0 occur in the same cycle, reset wins.
- Reset mid-frame aborts the frame: nothing further is written and cpu_rst returns to 1.
- Address arithmetic is modulo 2^ADDR_W. Because N ≤ MAX_WORDS, no wrap occurs for legal frames.

Decomposition:
- Package loader_pkg holds:
  - the state encoding (LEN0, LEN1, DATA, CSUM, DONE, ERR);
  - the err_code constants (ERR_NONE, ERR_LEN, ERR_CSUM, ERR_TMO).
- Sub-module word_packer holds:
  - the byte counter and the 32-bit little-endian shift/assemble register;
  - a word_valid pulse and clear on abort.
- The top level keeps the FSM, the XOR checksum, the timeout counter and the memory write register.

Test Plan:
- Normal load: send 02 00 05 00 08 20 04 00 09 8C AE.
  - mem_we at addr 0x0 with data 0x20080005, then at 0x4 with 0x8C090004.
  - done=1, cpu_rst=0, words_loaded=2, err=0.
- Bad checksum: same frame with final byte 0xAF.
  - Both words are written; then err=1, err_code=2, cpu_rst=1, in_ready=0.
- Overflow: length bytes 41 00 (N=65, MAX_WORDS=64).
  - ERR the cycle after the 2nd byte, err_code=1, no mem_we.
- Timeout: send 01 00 11 22, then hold in_valid=0 for TIMEOUT cycles.
  - err_code=3, no mem_we.
  - Then pulse start and send a good frame: loads correctly.
- Zero-length and backpressure:
  - Send 00 00 00: done=1, words_loaded=0, no mem_we.
  - Then send a 1-word frame with random in_valid gaps shorter than TIMEOUT: correct word written at 0x0.
- Reset mid-load: drop rst during the 3rd data byte.
  - All outputs at reset values next cycle, no further mem_we.
  - After release, a full frame loads normally.
